// File: rtl/jtoutrun_obj_pkg.sv
// Shared definitions for the object scheduler: sprite entry field layout and
// the dispatch state encoding.
package jtoutrun_obj_pkg;

  localparam int ENTRY_W    = 50;
  localparam int XPOS_LSB   = 0;
  localparam int XPOS_W     = 9;
  localparam int OFFSET_LSB = 9;
  localparam int OFFSET_W   = 16;
  localparam int BANK_LSB   = 25;
  localparam int BANK_W     = 3;
  localparam int PRIO_LSB   = 28;
  localparam int PRIO_W     = 2;
  localparam int SHADOW_BIT = 30;
  localparam int PAL_LSB    = 31;
  localparam int PAL_W      = 7;
  localparam int HZOOM_LSB  = 38;
  localparam int HZOOM_W    = 10;
  localparam int HFLIP_BIT  = 48;
  localparam int BACKWD_BIT = 49;

  localparam int ROM_AW = 18;
  localparam int ROM_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/jtoutrun_obj_romarb.sv
// Object ROM port arbiter: one owner at a time, with a short dead gap on every
// ownership change so a late obj_ok for the old address never reaches the new owner.
module jtoutrun_obj_romarb
  import jtoutrun_obj_pkg::*;
#(
  parameter int SWITCH_GAP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              d0_cs,
  input  logic              d1_cs,
  input  logic [ROM_AW-1:0] d0_addr,
  input  logic [ROM_AW-1:0] d1_addr,
  input  logic              obj_ok,
  output logic              obj_cs,
  output logic [ROM_AW-1:0] obj_addr,
  output logic              d0_ok,
  output logic              d1_ok
);

  localparam logic [1:0] GAP_INIT = 2'(SWITCH_GAP);

  logic       grant;
  logic [1:0] gap_cnt;
  logic       in_gap;
  logic       own_cs;
  logic       oth_cs;
  logic       swap;

  always_comb begin
    in_gap   = (gap_cnt != 2'd0);
    own_cs   = grant ? d1_cs : d0_cs;
    oth_cs   = grant ? d0_cs : d1_cs;
    // the owner keeps the port for as long as it holds cs
    swap     = ~in_gap & ~own_cs & oth_cs;
    obj_addr = grant ? d1_addr : d0_addr;
    obj_cs   = own_cs & ~in_gap & ~clr & ~rst;
    d0_ok    = obj_ok & obj_cs & ~grant;
    d1_ok    = obj_ok & obj_cs & grant;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      grant   <= 1'b0;
      gap_cnt <= 2'd0;
    end else if (swap) begin
      grant   <= ~grant;
      gap_cnt <= GAP_INIT;
    end else if (in_gap) begin
      gap_cnt <= gap_cnt - 2'd1;
    end
  end

endmodule

// File: rtl/jtoutrun_obj_sched.sv
// Object scheduler: dispatches scan entries to two draw engines and shares the
// object ROM port between them.
//
// state    | meaning
// ST_IDLE  | accepting entries while an engine is free
// ST_DRAIN | last entry taken, waiting for both engines to go idle
// ST_DONE  | line finished, holding until hstart
module jtoutrun_obj_sched
  import jtoutrun_obj_pkg::*;
#(
  parameter int SWITCH_GAP = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hstart,
  input  logic               scn_valid,
  output logic               scn_ready,
  input  logic               scn_last,
  input  logic [ENTRY_W-1:0] scn_entry,
  output logic               d0_start,
  output logic               d1_start,
  output logic [ENTRY_W-1:0] d0_entry,
  output logic [ENTRY_W-1:0] d1_entry,
  input  logic               d0_busy,
  input  logic               d1_busy,
  input  logic               d0_cs,
  input  logic               d1_cs,
  input  logic [ROM_AW-1:0]  d0_addr,
  input  logic [ROM_AW-1:0]  d1_addr,
  output logic               d0_ok,
  output logic               d1_ok,
  output logic [ROM_DW-1:0]  d0_data,
  output logic [ROM_DW-1:0]  d1_data,
  output logic               obj_cs,
  output logic [ROM_AW-1:0]  obj_addr,
  input  logic               obj_ok,
  input  logic [ROM_DW-1:0]  obj_data,
  output logic               line_done
);

  sched_state_t state, state_nxt;

  logic lock_0, lock_1;
  logic last_seen;
  logic free_0, free_1;
  logic accept, to_0, to_1;
  logic all_free;

  always_comb begin
    // lock masks the cycle between a start pulse and the engine raising busy
    free_0    = ~d0_busy & ~lock_0;
    free_1    = ~d1_busy & ~lock_1;
    all_free  = free_0 & free_1;
    scn_ready = ~rst & ~hstart & (state == ST_IDLE) & (free_0 | free_1);
    accept    = scn_valid & scn_ready;
    to_0      = accept & free_0;
    to_1      = accept & ~free_0;
    line_done = ~rst & ~hstart & (state == ST_DRAIN) & last_seen & all_free;
  end

  always_comb begin
    state_nxt = state;
    if (hstart) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (accept && scn_last) state_nxt = ST_DRAIN;
        ST_DRAIN: if (last_seen && all_free) state_nxt = ST_DONE;
        ST_DONE:  state_nxt = ST_DONE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d0_start  <= 1'b0;
      d1_start  <= 1'b0;
      lock_0    <= 1'b0;
      lock_1    <= 1'b0;
      last_seen <= 1'b0;
      d0_entry  <= '0;
      d1_entry  <= '0;
    end else if (hstart) begin
      d0_start  <= 1'b0;
      d1_start  <= 1'b0;
      lock_0    <= 1'b0;
      lock_1    <= 1'b0;
      last_seen <= 1'b0;
    end else begin
      d0_start <= to_0;
      d1_start <= to_1;
      lock_0   <= to_0;
      lock_1   <= to_1;
      if (accept) last_seen <= scn_last;
      if (to_0)   d0_entry  <= scn_entry;
      if (to_1)   d1_entry  <= scn_entry;
    end
  end

  assign d0_data = obj_data;
  assign d1_data = obj_data;

  jtoutrun_obj_romarb #(
    .SWITCH_GAP (SWITCH_GAP)
  ) u_romarb (
    .clk      (clk),
    .rst      (rst),
    .clr      (hstart),
    .d0_cs    (d0_cs),
    .d1_cs    (d1_cs),
    .d0_addr  (d0_addr),
    .d1_addr  (d1_addr),
    .obj_ok   (obj_ok),
    .obj_cs   (obj_cs),
    .obj_addr (obj_addr),
    .d0_ok    (d0_ok),
    .d1_ok    (d1_ok)
  );

endmodule

// File: tb/tb_jtoutrun_obj_sched.sv
// Directed bench for the object scheduler: dispatch scoreboard, ROM hand-over,
// line completion and hstart abort.
module tb_jtoutrun_obj_sched;

  localparam logic [17:0] A0 = 18'h00A0A;
  localparam logic [17:0] A1 = 18'h2B1B1;

  typedef struct packed {
    logic        eng;
    logic [49:0] entry;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, hstart, scn_valid, scn_last, obj_ok;
  logic        scn_ready, d0_start, d1_start, d0_ok, d1_ok, obj_cs, line_done;
  logic        d0_busy, d1_busy, d0_cs, d1_cs;
  logic [49:0] scn_entry, d0_entry, d1_entry;
  logic [17:0] d0_addr, d1_addr, obj_addr;
  logic [31:0] obj_data, d0_data, d1_data;

  int   n_pass = 0;
  int   n_chk  = 0;
  int   cyc    = 0;
  int   dur0   = 4;
  int   dur1   = 4;
  int   cnt0   = 0;
  int   cnt1   = 0;
  exp_t sb[$];
  int   start_cyc[$];
  logic [49:0] ents[7];

  jtoutrun_obj_sched #(.SWITCH_GAP(1)) dut (
    .clk(clk), .rst(rst), .hstart(hstart),
    .scn_valid(scn_valid), .scn_ready(scn_ready), .scn_last(scn_last), .scn_entry(scn_entry),
    .d0_start(d0_start), .d1_start(d1_start), .d0_entry(d0_entry), .d1_entry(d1_entry),
    .d0_busy(d0_busy), .d1_busy(d1_busy), .d0_cs(d0_cs), .d1_cs(d1_cs),
    .d0_addr(d0_addr), .d1_addr(d1_addr), .d0_ok(d0_ok), .d1_ok(d1_ok),
    .d0_data(d0_data), .d1_data(d1_data),
    .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_ok(obj_ok), .obj_data(obj_data),
    .line_done(line_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // draw engine stand-ins: busy for durN cycles starting the cycle after start
  always @(posedge clk) begin
    if (rst || hstart)  cnt0 <= 0;
    else if (d0_start)  cnt0 <= dur0;
    else if (cnt0 != 0) cnt0 <= cnt0 - 1;
    if (rst || hstart)  cnt1 <= 0;
    else if (d1_start)  cnt1 <= dur1;
    else if (cnt1 != 0) cnt1 <= cnt1 - 1;
  end
  assign d0_busy = (cnt0 != 0);
  assign d1_busy = (cnt1 != 0);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [49:0] e, input logic l, input int maxc);
    int n;
    n = 0;
    scn_valid = 1'b1;
    scn_entry = e;
    scn_last  = l;
    #1;
    while (scn_ready !== 1'b1 && n < maxc) begin
      tick();
      #1;
      n++;
    end
    chk("send_accept", 64'(n < maxc), 64'(1));
    tick();
    scn_valid = 1'b0;
    scn_last  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && (d0_start || d1_start)) begin
      exp_t e;
      start_cyc.push_back(cyc);
      chk("single_start", 64'(d0_start & d1_start), 64'(0));
      if (sb.size() == 0) begin
        chk("unexpected_start", 64'({d1_start, d0_start}), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("start_engine", 64'(d1_start), 64'(e.eng));
        chk("start_entry", 64'(e.eng ? d1_entry : d0_entry), 64'(e.entry));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, done_cnt, done_cyc, rdy_seen, cs_seen;
    ents[0] = 50'h1_2345_6789_ABCD;
    ents[1] = 50'h2_F00D_CAFE_0001;
    ents[2] = 50'h0_1111_2222_3333;
    ents[3] = 50'h3_4444_5555_6666;
    ents[4] = 50'h1_7777_8888_9999;
    ents[5] = 50'h2_AAAA_BBBB_CCCC;
    ents[6] = 50'h3_DDDD_EEEE_FFFF;
    rst = 1'b1; hstart = 1'b0; scn_valid = 1'b0; scn_last = 1'b0; scn_entry = '0;
    d0_cs = 1'b0; d1_cs = 1'b0; d0_addr = A0; d1_addr = A1;
    obj_ok = 1'b0; obj_data = 32'hDEADBEEF;
    repeat (2) tick();
    rst = 1'b0;
    #1 chk("ready_idle", 64'(scn_ready), 64'(1));

    // dispatch to engine 0 while engine 1 takes the ROM, then reset mid-flight
    d1_cs = 1'b1;
    scn_valid = 1'b1; scn_entry = ents[0];
    sb.push_back('{1'b0, ents[0]});
    tick();
    scn_valid = 1'b0;
    #1 chk("pre_gap_cs", 64'(obj_cs), 64'(0));
    chk("pre_gap_addr", 64'(obj_addr), 64'(A1));
    tick();
    chk("pre_own1_cs", 64'(obj_cs), 64'(1));
    chk("pre_own1_addr", 64'(obj_addr), 64'(A1));
    rst = 1'b1; d0_cs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ready", 64'(scn_ready), 64'(0));
      chk("rst_start", 64'({d0_start, d1_start}), 64'(0));
      chk("rst_entry", 64'(d0_entry | d1_entry), 64'(0));
      chk("rst_cs", 64'(obj_cs), 64'(0));
      chk("rst_grant", 64'(obj_addr), 64'(A0));
      chk("rst_done", 64'(line_done), 64'(0));
    end
    rst = 1'b0; d0_cs = 1'b0; d1_cs = 1'b0;
    sb.push_back('{1'b0, ents[1]});
    send(ents[1], 1'b0, 4);
    repeat (8) tick();

    // three back-to-back entries, 20-cycle engines
    dur0 = 20; dur1 = 20;
    base = start_cyc.size();
    sb.push_back('{1'b0, ents[2]});
    sb.push_back('{1'b1, ents[3]});
    sb.push_back('{1'b0, ents[4]});
    send(ents[2], 1'b0, 40);
    send(ents[3], 1'b0, 40);
    send(ents[4], 1'b0, 60);
    repeat (3) tick();
    chk("b2b_count", 64'(start_cyc.size()), 64'(base + 3));
    if (start_cyc.size() >= base + 3) begin
      chk("b2b_second", 64'(start_cyc[base+1] - start_cyc[base]), 64'(1));
      chk("b2b_third", 64'(start_cyc[base+2] - start_cyc[base]), 64'(22));
    end
    repeat (30) tick();

    // ROM hand-over from engine 0 to engine 1
    d0_cs = 1'b1;
    tick();
    chk("own0_cs", 64'(obj_cs), 64'(1));
    chk("own0_addr", 64'(obj_addr), 64'(A0));
    d1_cs = 1'b1;
    tick();
    chk("keep0_addr", 64'(obj_addr), 64'(A0));
    obj_ok = 1'b1;
    #1 chk("keep0_ok", 64'({d0_ok, d1_ok}), 64'(2'b10));
    obj_ok = 1'b0; d0_cs = 1'b0;
    #1 chk("sw_t_cs", 64'(obj_cs), 64'(0));
    tick();
    obj_ok = 1'b1;
    #1 chk("gap_cs", 64'(obj_cs), 64'(0));
    chk("gap_ok", 64'({d0_ok, d1_ok}), 64'(0));
    chk("gap_addr", 64'(obj_addr), 64'(A1));
    obj_ok = 1'b0;
    tick();
    chk("own1_cs", 64'(obj_cs), 64'(1));
    chk("own1_addr", 64'(obj_addr), 64'(A1));
    obj_ok = 1'b1;
    #1 chk("own1_ok", 64'({d0_ok, d1_ok}), 64'(2'b01));
    obj_ok = 1'b0; d1_cs = 1'b0;
    tick();
    chk("idle_hold_addr", 64'(obj_addr), 64'(A1));
    chk("idle_hold_cs", 64'(obj_cs), 64'(0));

    // last entry, then drain to a single line_done
    dur0 = 40; dur1 = 80;
    base = start_cyc.size();
    sb.push_back('{1'b0, ents[5]});
    sb.push_back('{1'b1, ents[6]});
    send(ents[5], 1'b0, 10);
    send(ents[6], 1'b1, 10);
    #1 chk("drain_ready", 64'(scn_ready), 64'(0));
    scn_valid = 1'b1; scn_entry = ents[0];
    done_cnt = 0; done_cyc = -1; rdy_seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (line_done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (scn_ready !== 1'b0) rdy_seen++;
      tick();
    end
    chk("done_count", 64'(done_cnt), 64'(1));
    chk("drain_ready_hold", 64'(rdy_seen), 64'(0));
    chk("drain_starts", 64'(start_cyc.size()), 64'(base + 2));
    if (start_cyc.size() >= base + 2)
      chk("done_cycle", 64'(done_cyc), 64'(start_cyc[base+1] + 81));
    scn_valid = 1'b0;
    hstart = 1'b1;
    tick();
    hstart = 1'b0;
    #1 chk("hs_reopen_ready", 64'(scn_ready), 64'(1));

    // hstart against an active owner, then against an entry and a pending switch
    d0_cs = 1'b1;
    repeat (2) tick();
    chk("pre_hs_cs", 64'(obj_cs), 64'(1));
    chk("pre_hs_addr", 64'(obj_addr), 64'(A0));
    hstart = 1'b1; obj_ok = 1'b1;
    #1 chk("hs_cs", 64'(obj_cs), 64'(0));
    chk("hs_ok", 64'({d0_ok, d1_ok}), 64'(0));
    tick();
    obj_ok = 1'b0;
    scn_valid = 1'b1; scn_entry = ents[2]; d0_cs = 1'b0; d1_cs = 1'b1;
    #1 chk("hs_ready", 64'(scn_ready), 64'(0));
    tick();
    hstart = 1'b0; scn_valid = 1'b0; d1_cs = 1'b0;
    #1 chk("hs_no_start", 64'({d0_start, d1_start}), 64'(0));
    chk("hs_grant", 64'(obj_addr), 64'(A0));
    chk("hs_cs_after", 64'(obj_cs), 64'(0));

    // an empty line produces no line_done and no ROM traffic
    hstart = 1'b1;
    tick();
    hstart = 1'b0;
    done_cnt = 0; cs_seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (line_done === 1'b1) done_cnt++;
      if (obj_cs !== 1'b0) cs_seen++;
    end
    chk("empty_done", 64'(done_cnt), 64'(0));
    chk("empty_cs", 64'(cs_seen), 64'(0));
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
